// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the IFU, the LSU and the memory port.
// The master view is the arbiter; the slave view is its environment.
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic        ifu_respErr;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_wen;
  logic        lsu_respValid;
  logic        lsu_respErr;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wen;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  modport master (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr,
    input  lsu_wdata, lsu_wmask, lsu_wen,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_respErr,
    output ifu_rdata,
    output lsu_respValid, lsu_respErr,
    output lsu_rdata,
    output mem_reqValid, mem_addr,
    output mem_wdata, mem_wmask, mem_wen
  );

  modport slave (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr,
    output lsu_wdata, lsu_wmask, lsu_wen,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_respErr,
    input  ifu_rdata,
    input  lsu_respValid, lsu_respErr,
    input  lsu_rdata,
    input  mem_reqValid, mem_addr,
    input  mem_wdata, mem_wmask, mem_wen
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU,
// with per-transaction timeout that returns an error response.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic   clock,
  input  logic   reset,
  mem_arbiter_if.master bus
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IFU,
    BUSY_LSU
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_lsu_q, last_lsu_d;

  logic          pend_ifu_q, pend_lsu_q;
  logic [31:0]   ifu_addr_q;
  logic [31:0]   lsu_addr_q;
  logic [31:0]   lsu_wdata_q;
  logic [3:0]    lsu_wmask_q;
  logic          lsu_wen_q;

  logic          grant_ifu, grant_lsu;
  logic          timeout;
  logic          done_ifu, done_lsu;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_lsu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  // A new pulse beats the clear from a same-cycle completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_ifu_q  <= 1'b0;
      pend_lsu_q  <= 1'b0;
      ifu_addr_q  <= '0;
      lsu_addr_q  <= '0;
      lsu_wdata_q <= '0;
      lsu_wmask_q <= '0;
      lsu_wen_q   <= 1'b0;
    end else begin
      if (bus.ifu_reqValid) begin
        pend_ifu_q <= 1'b1;
        ifu_addr_q <= bus.ifu_addr;
      end else if (done_ifu) begin
        pend_ifu_q <= 1'b0;
      end
      if (bus.lsu_reqValid) begin
        pend_lsu_q  <= 1'b1;
        lsu_addr_q  <= bus.lsu_addr;
        lsu_wdata_q <= bus.lsu_wdata;
        lsu_wmask_q <= bus.lsu_wmask;
        lsu_wen_q   <= bus.lsu_wen;
      end else if (done_lsu) begin
        pend_lsu_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_lsu_d = last_lsu_q;
    grant_ifu  = 1'b0;
    grant_lsu  = 1'b0;
    done_ifu   = 1'b0;
    done_lsu   = 1'b0;
    timeout    = TO_EN && (cnt_q == CNT_LAST);

    bus.ifu_respValid = 1'b0;
    bus.ifu_respErr   = 1'b0;
    bus.ifu_rdata     = '0;
    bus.lsu_respValid = 1'b0;
    bus.lsu_respErr   = 1'b0;
    bus.lsu_rdata     = '0;
    bus.mem_reqValid  = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = '0;
    bus.mem_wen       = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_lsu = pend_lsu_q &&
                    (!pend_ifu_q || !last_lsu_q);
        grant_ifu = pend_ifu_q && !grant_lsu;
        if (grant_lsu) begin
          bus.mem_reqValid = 1'b1;
          bus.mem_addr     = lsu_addr_q;
          bus.mem_wdata    = lsu_wdata_q;
          bus.mem_wmask    = lsu_wmask_q;
          bus.mem_wen      = lsu_wen_q;
          last_lsu_d       = 1'b1;
          cnt_d            = '0;
          state_d          = BUSY_LSU;
        end else if (grant_ifu) begin
          bus.mem_reqValid = 1'b1;
          bus.mem_addr     = ifu_addr_q;
          last_lsu_d       = 1'b0;
          cnt_d            = '0;
          state_d          = BUSY_IFU;
        end
      end
      BUSY_IFU: begin
        bus.mem_addr = ifu_addr_q;
        if (bus.mem_respValid) begin
          bus.ifu_respValid = 1'b1;
          bus.ifu_rdata     = bus.mem_rdata;
          done_ifu          = 1'b1;
          state_d           = IDLE;
        end else if (timeout) begin
          bus.ifu_respValid = 1'b1;
          bus.ifu_respErr   = 1'b1;
          done_ifu          = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY_LSU: begin
        bus.mem_addr  = lsu_addr_q;
        bus.mem_wdata = lsu_wdata_q;
        bus.mem_wmask = lsu_wmask_q;
        bus.mem_wen   = lsu_wen_q;
        if (bus.mem_respValid) begin
          bus.lsu_respValid = 1'b1;
          bus.lsu_rdata     = bus.mem_rdata;
          done_lsu          = 1'b1;
          state_d           = IDLE;
        end else if (timeout) begin
          bus.lsu_respValid = 1'b1;
          bus.lsu_respErr   = 1'b1;
          done_lsu          = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, routing,
// misaligned follow-on, timeout and mid-transaction reset.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    bus.ifu_reqValid  = 1'b0;
    bus.lsu_reqValid  = 1'b0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic ifu_req(input logic [31:0] a);
    bus.ifu_reqValid = 1'b1;
    bus.ifu_addr     = a;
  endtask

  task automatic lsu_req(input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0]  m,
                         input logic        w);
    bus.lsu_reqValid = 1'b1;
    bus.lsu_addr     = a;
    bus.lsu_wdata    = d;
    bus.lsu_wmask    = m;
    bus.lsu_wen      = w;
  endtask

  task automatic resp(input logic [31:0] d);
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = d;
  endtask

  initial begin
    bus.ifu_reqValid  = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_reqValid  = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.lsu_wen       = 1'b0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;

    // Reset held: outputs quiet even with a stray response
    repeat (2) @(posedge clock);
    @(negedge clock);
    resp(32'h1234_5678);
    #1;
    chk("rst_memreq", 32'(bus.mem_reqValid), 0);
    chk("rst_memaddr", bus.mem_addr, 0);
    chk("rst_lsuresp", 32'(bus.lsu_respValid), 0);
    chk("rst_ifuresp", 32'(bus.ifu_respValid), 0);
    chk("rst_ifurdata", bus.ifu_rdata, 0);
    cyc();
    reset = 1'b0;

    // Tie from reset (last_grant=IFU): LSU first
    ifu_req(32'h80);
    lsu_req(32'h200, 32'hA5A5_0F0F, 4'hF, 1'b1);
    @(negedge clock);
    chk("tie_same_cycle", 32'(bus.mem_reqValid), 0);
    cyc();
    @(negedge clock);
    chk("tie_lsu_req", 32'(bus.mem_reqValid), 1);
    chk("tie_lsu_addr", bus.mem_addr, 32'h200);
    chk("tie_lsu_wen", 32'(bus.mem_wen), 1);
    chk("tie_lsu_wmask", 32'(bus.mem_wmask), 32'hF);
    chk("tie_lsu_wdata", bus.mem_wdata, 32'hA5A5_0F0F);
    cyc();
    resp(32'h11);
    @(negedge clock);
    chk("tie_lsu_resp", 32'(bus.lsu_respValid), 1);
    chk("tie_ifu_noresp", 32'(bus.ifu_respValid), 0);
    chk("tie_resp_noreq", 32'(bus.mem_reqValid), 0);
    cyc();
    @(negedge clock);
    chk("tie_ifu_req", 32'(bus.mem_reqValid), 1);
    chk("tie_ifu_addr", bus.mem_addr, 32'h80);
    chk("tie_ifu_wmask", 32'(bus.mem_wmask), 0);
    chk("tie_ifu_wen", 32'(bus.mem_wen), 0);
    chk("tie_ifu_wdata", bus.mem_wdata, 0);
    cyc();
    resp(32'hCAFE_F00D);
    @(negedge clock);
    chk("tie_ifu_resp", 32'(bus.ifu_respValid), 1);
    chk("tie_ifu_rdata", bus.ifu_rdata, 32'hCAFE_F00D);
    chk("tie_ifu_err", 32'(bus.ifu_respErr), 0);
    chk("tie_lsu_quiet", 32'(bus.lsu_respValid), 0);
    cyc();

    // Plain load, no contention
    lsu_req(32'h100, 32'h0, 4'h0, 1'b0);
    @(negedge clock);
    chk("ld_c0_noreq", 32'(bus.mem_reqValid), 0);
    cyc();
    @(negedge clock);
    chk("ld_c1_req", 32'(bus.mem_reqValid), 1);
    chk("ld_c1_addr", bus.mem_addr, 32'h100);
    chk("ld_c1_wen", 32'(bus.mem_wen), 0);
    cyc();
    @(negedge clock);
    chk("ld_c2_pulse", 32'(bus.mem_reqValid), 0);
    chk("ld_c2_hold", bus.mem_addr, 32'h100);
    cyc();
    resp(32'hDEAD_BEEF);
    @(negedge clock);
    chk("ld_c3_resp", 32'(bus.lsu_respValid), 1);
    chk("ld_c3_rdata", bus.lsu_rdata, 32'hDEAD_BEEF);
    chk("ld_c3_err", 32'(bus.lsu_respErr), 0);
    cyc();
    @(negedge clock);
    chk("ld_idle_addr", bus.mem_addr, 0);
    chk("ld_idle_lsu", 32'(bus.lsu_respValid), 0);

    // Tie after an LSU grant: IFU wins
    ifu_req(32'h90);
    lsu_req(32'h300, 32'h0, 4'h0, 1'b0);
    cyc();
    @(negedge clock);
    chk("tie2_ifu_req", 32'(bus.mem_reqValid), 1);
    chk("tie2_ifu_addr", bus.mem_addr, 32'h90);
    cyc();
    resp(32'h22);
    @(negedge clock);
    chk("tie2_ifu_resp", 32'(bus.ifu_respValid), 1);
    cyc();
    @(negedge clock);
    chk("tie2_lsu_addr", bus.mem_addr, 32'h300);
    cyc();
    resp(32'h33);
    @(negedge clock);
    chk("tie2_lsu_rdata", bus.lsu_rdata, 32'h33);
    cyc();

    // IFU arrives while BUSY_LSU
    lsu_req(32'h400, 32'h0, 4'h0, 1'b0);
    cyc();
    @(negedge clock);
    chk("ct_lsu_addr", bus.mem_addr, 32'h400);
    cyc();
    ifu_req(32'hA0);
    @(negedge clock);
    chk("ct_held_noreq", 32'(bus.mem_reqValid), 0);
    chk("ct_held_addr", bus.mem_addr, 32'h400);
    cyc();
    resp(32'h44);
    @(negedge clock);
    chk("ct_lsu_resp", 32'(bus.lsu_respValid), 1);
    chk("ct_ifu_noresp", 32'(bus.ifu_respValid), 0);
    cyc();
    @(negedge clock);
    chk("ct_ifu_req", 32'(bus.mem_reqValid), 1);
    chk("ct_ifu_addr", bus.mem_addr, 32'hA0);
    chk("ct_ifu_wmask", 32'(bus.mem_wmask), 0);
    chk("ct_ifu_wen", 32'(bus.mem_wen), 0);
    cyc();
    resp(32'h55);
    @(negedge clock);
    chk("ct_ifu_rdata", bus.ifu_rdata, 32'h55);
    cyc();

    // Misaligned: second half requested in response cycle
    lsu_req(32'h102, 32'h0, 4'h0, 1'b0);
    cyc();
    cyc();
    resp(32'h66);
    lsu_req(32'h104, 32'h0, 4'h0, 1'b0);
    @(negedge clock);
    chk("mis_resp1", 32'(bus.lsu_respValid), 1);
    chk("mis_resp1_noreq", 32'(bus.mem_reqValid), 0);
    cyc();
    @(negedge clock);
    chk("mis_req2", 32'(bus.mem_reqValid), 1);
    chk("mis_req2_addr", bus.mem_addr, 32'h104);
    cyc();
    resp(32'h77);
    @(negedge clock);
    chk("mis_resp2", bus.lsu_rdata, 32'h77);
    cyc();

    // Timeout: error on 4th BUSY cycle, late response ignored
    ifu_req(32'hB0);
    cyc();
    @(negedge clock);
    chk("to_req", 32'(bus.mem_reqValid), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      @(negedge clock);
      chk($sformatf("to_busy%0d", i),
          32'(bus.ifu_respValid), 0);
    end
    cyc();
    @(negedge clock);
    chk("to_resp", 32'(bus.ifu_respValid), 1);
    chk("to_err", 32'(bus.ifu_respErr), 1);
    chk("to_rdata", bus.ifu_rdata, 0);
    cyc();
    resp(32'h88);
    @(negedge clock);
    chk("to_late_resp", 32'(bus.ifu_respValid), 0);
    chk("to_late_rdata", bus.ifu_rdata, 0);
    chk("to_late_noreq", 32'(bus.mem_reqValid), 0);
    cyc();

    // Reset in BUSY_LSU with IFU pending
    lsu_req(32'h500, 32'h0, 4'h0, 1'b0);
    cyc();
    cyc();
    ifu_req(32'hC0);
    cyc();
    reset = 1'b1;
    resp(32'h99);
    #1;
    chk("mr_memaddr", bus.mem_addr, 0);
    chk("mr_lsuresp", 32'(bus.lsu_respValid), 0);
    chk("mr_lsurdata", bus.lsu_rdata, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) resp(32'hAA);
      @(negedge clock);
      chk($sformatf("mr_quiet%0d", i),
          32'(bus.mem_reqValid), 0);
      chk($sformatf("mr_noresp%0d", i),
          32'(bus.lsu_respValid), 0);
      cyc();
    end
    ifu_req(32'hD0);
    cyc();
    @(negedge clock);
    chk("mr_new_req", 32'(bus.mem_reqValid), 1);
    chk("mr_new_addr", bus.mem_addr, 32'hD0);
    cyc();
    resp(32'hBB);
    @(negedge clock);
    chk("mr_new_resp", bus.ifu_rdata, 32'hBB);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
